// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid
// buffer. Back-pressure never propagates combinationally: in_ready is
// decoded from registered state only. Includes a synchronous flush and a
// saturating stall-cycle counter.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state_q,     state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic                acc_s;
  logic                pop_s;

  // Decode the handshake outputs from registered state only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      ST_EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
      ST_ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_TWO: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
    out_data  = main_data_q;
    stall_cnt = stall_cnt_q;
    acc_s     = in_valid && in_ready;
    pop_s     = out_valid && out_ready;
  end

  // Next-state logic: skid-buffer transitions, flush squash, stall counting.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    stall_cnt_d = stall_cnt_q;

    // Flush does not clear the counter; it only reflects downstream stalls.
    if (out_valid && !out_ready) begin
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    if (flush) begin
      // Any word accepted this cycle is discarded; a concurrent pop has
      // already been seen downstream, so nothing else needs to happen.
      state_d     = ST_EMPTY;
      main_data_d = '0;
      skid_data_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc_s) begin
            main_data_d = in_data;
            state_d     = ST_ONE;
          end else begin
            state_d     = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (acc_s && pop_s) begin
            main_data_d = in_data;
            state_d     = ST_ONE;
          end else if (acc_s) begin
            skid_data_d = in_data;
            state_d     = ST_TWO;
          end else if (pop_s) begin
            state_d     = ST_EMPTY;
          end else begin
            state_d     = ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            main_data_d = skid_data_q;
            state_d     = ST_ONE;
          end else begin
            state_d     = ST_TWO;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_data_d = '0;
          skid_data_d = '0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset overriding everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a table of cycle vectors with expected
// outputs, plus hand-written reset-in-TWO and counter-saturation sequences.
module tb_pipe_stage_buf;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready_a,  out_valid_a;
  logic [31:0] out_data_a;
  logic [1:0]  occ_a;
  logic [15:0] stall_a;

  logic        in_ready_b,  out_valid_b;
  logic [31:0] out_data_b;
  logic [1:0]  occ_b;
  logic [3:0]  stall_b;

  int n_cmp;
  int n_fail;

  pipe_stage_buf #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .occupancy(occ_a), .stall_cnt(stall_a)
  );

  pipe_stage_buf #(.DATA_W(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .occupancy(occ_b), .stall_cnt(stall_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] data;
    logic        ordy;
    logic        chk_data;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  occ;
    logic        ir;
    logic [15:0] sc;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] d,
                     input logic ordy, input logic cd, input logic ov, input logic [31:0] od,
                     input logic [1:0] occ, input logic ir, input logic [15:0] sc);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.data = d; v.ordy = ordy; v.chk_data = cd;
    v.ov = ov; v.od = od; v.occ = occ; v.ir = ir; v.sc = sc;
    tbl.push_back(v);
  endtask

  // Apply inputs, clock once, and sample one time unit after the edge.
  task automatic step(input logic r, input logic f, input logic iv, input logic [31:0] d,
                      input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    #2;

    //   rst   flush iv    data           ordy  chkd  ov    od            occ   ir    sc
    // reset with a live input presented
    add(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0,        2'd0, 1'b1, 16'd0);
    add(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0,        2'd0, 1'b1, 16'd0);
    add(1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0,        2'd0, 1'b1, 16'd0);
    // streaming with out_ready high
    for (int k = 1; k <= 8; k++) begin
      add(1'b1, 1'b0, 1'b1, k,          1'b1, 1'b1, 1'b1, k,            2'd1, 1'b1, 16'd0);
    end
    add(1'b1, 1'b0, 1'b0, 32'h55555555, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0, 1'b1, 16'd0);
    // back-pressure: A, B accepted; C held upstream until drain
    add(1'b1, 1'b0, 1'b1, 32'hA,        1'b0, 1'b1, 1'b1, 32'hA,        2'd1, 1'b1, 16'd0);
    add(1'b1, 1'b0, 1'b1, 32'hB,        1'b0, 1'b1, 1'b1, 32'hA,        2'd2, 1'b0, 16'd1);
    add(1'b1, 1'b0, 1'b1, 32'hC,        1'b0, 1'b1, 1'b1, 32'hA,        2'd2, 1'b0, 16'd2);
    add(1'b1, 1'b0, 1'b1, 32'hC,        1'b0, 1'b1, 1'b1, 32'hA,        2'd2, 1'b0, 16'd3);
    add(1'b1, 1'b0, 1'b1, 32'hC,        1'b1, 1'b1, 1'b1, 32'hB,        2'd1, 1'b1, 16'd3);
    add(1'b1, 1'b0, 1'b1, 32'hC,        1'b1, 1'b1, 1'b1, 32'hC,        2'd1, 1'b1, 16'd3);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        2'd0, 1'b1, 16'd3);
    // flush while TWO, input presented; counter retained
    add(1'b1, 1'b0, 1'b1, 32'hD,        1'b0, 1'b1, 1'b1, 32'hD,        2'd1, 1'b1, 16'd3);
    add(1'b1, 1'b0, 1'b1, 32'hE,        1'b0, 1'b1, 1'b1, 32'hD,        2'd2, 1'b0, 16'd4);
    add(1'b1, 1'b1, 1'b1, 32'hF,        1'b0, 1'b1, 1'b0, 32'h0,        2'd0, 1'b1, 16'd5);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        2'd0, 1'b1, 16'd5);
    // flush while ONE with a real concurrent accept: the word is discarded
    add(1'b1, 1'b0, 1'b1, 32'h1234,     1'b0, 1'b1, 1'b1, 32'h1234,     2'd1, 1'b1, 16'd5);
    add(1'b1, 1'b1, 1'b1, 32'h5678,     1'b0, 1'b1, 1'b0, 32'h0,        2'd0, 1'b1, 16'd6);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        2'd0, 1'b1, 16'd6);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].data, tbl[i].ordy);
      check($sformatf("v%0d out_valid", i), {31'b0, out_valid_a}, {31'b0, tbl[i].ov});
      check($sformatf("v%0d occupancy", i), {30'b0, occ_a}, {30'b0, tbl[i].occ});
      check($sformatf("v%0d in_ready", i), {31'b0, in_ready_a}, {31'b0, tbl[i].ir});
      check($sformatf("v%0d stall_cnt", i), {16'b0, stall_a}, {16'b0, tbl[i].sc});
      check($sformatf("v%0d sat_stall", i), {28'b0, stall_b}, {28'b0, tbl[i].sc[3:0]});
      if (tbl[i].chk_data) begin
        check($sformatf("v%0d out_data", i), out_data_a, tbl[i].od);
      end else begin
        check($sformatf("v%0d out_valid_sat", i), {31'b0, out_valid_b}, {31'b0, tbl[i].ov});
      end
    end

    // Reset asserted while in TWO with out_ready toggling.
    step(1'b1, 1'b0, 1'b1, 32'h77, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h88, 1'b0);
    check("rst_mid pre occupancy", {30'b0, occ_a}, 32'd2);
    step(1'b0, 1'b0, 1'b1, 32'h99, 1'b1);
    check("rst_mid out_valid", {31'b0, out_valid_a}, 32'd0);
    check("rst_mid out_data", out_data_a, 32'h0);
    check("rst_mid occupancy", {30'b0, occ_a}, 32'd0);
    check("rst_mid in_ready", {31'b0, in_ready_a}, 32'd1);
    check("rst_mid stall_cnt", {16'b0, stall_a}, 32'd0);
    check("rst_mid sat_stall", {28'b0, stall_b}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h99, 1'b0);
    check("rst_mid2 occupancy", {30'b0, occ_a}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_rel out_valid", {31'b0, out_valid_a}, 32'd0);
    check("rst_rel skid empty", {31'b0, out_valid_b}, 32'd0);

    // Stall counter saturation: one word held for 20 stalled cycles.
    step(1'b1, 1'b0, 1'b1, 32'hCAFE, 1'b0);
    check("sat load out_data", out_data_b, 32'hCAFE);
    check("sat load stall", {28'b0, stall_b}, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'hBAD0 + k, 1'b0);
      check($sformatf("sat c%0d stall4", k), {28'b0, stall_b}, (k > 15) ? 32'd15 : k);
      check($sformatf("sat c%0d stall16", k), {16'b0, stall_a}, k);
      check($sformatf("sat c%0d out_data", k), out_data_a, 32'hCAFE);
      check($sformatf("sat c%0d out_valid", k), {31'b0, out_valid_a}, 32'd1);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("sat drain stall4", {28'b0, stall_b}, 32'd15);
    check("sat drain empty", {30'b0, occ_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
